// File: rtl/ahb_lite_rr_master.sv
// ahb_lite_rr_master: two-requester AHB-Lite master with round-robin
// arbitration, one outstanding non-pipelined transfer, and a wait-state
// timeout that turns a stuck slave into an error completion.
//
// Ports
//   HCLK, HRESETn        clock, async active-low reset
//   reqN/weN/addrN/wdataN requester N transfer request and payload (N=0,1)
//   doneN                one-cycle completion pulse to requester N
//   err, rdata           completion status / read data, valid with a done
//   HSEL..HREADY         AHB-Lite master outputs towards the slave
//   HRDATA, HREADYOUT, HRESP  slave responses
module ahb_lite_rr_master #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HREADYOUT,
  input  logic [1:0]  HRESP
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;     // requester granted most recently
  logic             gnt_q, gnt_d;       // requester owning the transfer
  logic             we_q, we_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    hwdata_q, hwdata_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic win;
  logic complete;
  logic timeout;

  // State and latched-transfer registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state, arbitration and completion logic
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    wait_d   = wait_q;
    complete = 1'b0;
    timeout  = 1'b0;

    // On a tie the requester that did not win last time goes next
    win = (req0 && req1) ? ~last_q : req1;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        wait_d   = '0;
        hwdata_d = wdata_q;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (HREADYOUT) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_q == CNT_W'(WAIT_MAX - 1)) begin
          complete = 1'b1;
          timeout  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completion outputs are combinational so done lands in the data cycle
  always_comb begin
    done0 = complete && !gnt_q;
    done1 = complete && gnt_q;
    err   = complete && (timeout || (HRESP != 2'b00));
    rdata = (complete && !timeout) ? HRDATA : '0;
  end

  // AHB outputs; address/data hold their last values via the latches
  always_comb begin
    HSEL   = (state_q == ST_ADDR);
    HTRANS = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    HADDR  = addr_q;
    HWRITE = we_q;
    HSIZE  = 3'b010;
    HWDATA = hwdata_q;
    HREADY = (state_q == ST_DATA) ? HREADYOUT : 1'b1;
  end

endmodule

// File: tb/tb_ahb_lite_rr_master.sv
// Bench for ahb_lite_rr_master: table of single transfers with a behavioural
// slave, plus hand-written round-robin and mid-transfer reset sequences.
// Expected completions are queued when a request is driven and popped when
// the design pulses done.
module tb_ahb_lite_rr_master;

  localparam int unsigned WAIT_MAX = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err;
  logic [31:0] rdata;
  logic        HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  ahb_lite_rr_master #(.WAIT_MAX(WAIT_MAX)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;      // wait states the slave inserts
    logic [1:0]  hresp;      // response in the ready cycle
    logic [31:0] slv_rdata;  // HRDATA driven during the data phase
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsel"},   64'(HSEL),   64'd0);
    check({tag, "_htrans"}, 64'(HTRANS), 64'd0);
    check({tag, "_haddr"},  64'(HADDR),  64'd0);
    check({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
    check({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
    check({tag, "_hready"}, 64'(HREADY), 64'd1);
    check({tag, "_cmpl"},   64'({done0, done1, err, rdata}), 64'd0);
  endtask

  task automatic set_req(input logic id, input logic val, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin req1 = val; we1 = we; addr1 = addr; wdata1 = wdata; end
    else    begin req0 = val; we0 = we; addr0 = addr; wdata0 = wdata; end
  endtask

  // Compare a done cycle against the oldest queued expectation
  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_done"},  64'({done1, done0}), e.id ? 64'd2 : 64'd1);
      check({tag, "_err"},   64'(err),   64'(e.err));
      check({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
    end
  endtask

  // Called just after a rising edge with the design in IDLE; returns likewise
  task automatic run_xfer(input vec_t v, input string tag);
    exp_t        e;
    int unsigned exp_idx;
    logic        tmo;
    tmo     = (v.waits >= WAIT_MAX);
    exp_idx = tmo ? WAIT_MAX - 1 : v.waits;
    e.id = v.id; e.err = v.exp_err; e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    set_req(v.id, 1'b1, v.we, v.addr, v.wdata);

    @(posedge HCLK); #1;
    @(negedge HCLK);
    check({tag, "_a_hsel"},   64'(HSEL),   64'd1);
    check({tag, "_a_htrans"}, 64'(HTRANS), 64'd2);
    check({tag, "_a_haddr"},  64'(HADDR),  64'(v.addr));
    check({tag, "_a_hwrite"}, 64'(HWRITE), 64'(v.we));
    check({tag, "_a_hsize"},  64'(HSIZE),  64'd2);
    check({tag, "_a_nodone"}, 64'({done0, done1}), 64'd0);

    for (int unsigned i = 0; i <= exp_idx; i++) begin
      @(posedge HCLK); #1;
      HREADYOUT = (i < v.waits) ? 1'b0 : 1'b1;
      HRESP     = (i < v.waits) ? 2'b00 : v.hresp;
      HRDATA    = v.slv_rdata;
      @(negedge HCLK);
      check({tag, "_d_hready"}, 64'(HREADY), (i < v.waits) ? 64'd0 : 64'd1);
      check({tag, "_d_bus"},    64'({HSEL, HTRANS}), 64'd0);
      check({tag, "_d_hwdata"}, 64'(HWDATA), 64'(v.wdata));
      if (i < exp_idx) check({tag, "_d_wait_cmpl"}, 64'({done0, done1, err, rdata}), 64'd0);
      else             pop_and_check(tag);
    end
    set_req(v.id, 1'b0, v.we, v.addr, v.wdata);
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;

    @(posedge HCLK); #1;
    check({tag, "_i_hold_haddr"},  64'(HADDR),  64'(v.addr));
    check({tag, "_i_hold_hwdata"}, 64'(HWDATA), 64'(v.wdata));
    check({tag, "_i_idle"},        64'({HSEL, HTRANS, HREADY, done0, done1}), 64'b0_00_1_0_0);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    int   ndone;
    HRESETn = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    HRDATA = '0; HREADYOUT = 1'b1; HRESP = 2'b00;

    //          id    we    addr          wdata         waits hresp  slv_rdata     err   rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 0,  2'b00, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0008, 32'h1111_2222, 2,  2'b00, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         0,  2'b01, 32'h0000_1234, 1'b1, 32'h0000_1234};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 3,  2'b00, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         99, 2'b00, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h5A5A_0000, 1,  2'b11, 32'h7777_8888, 1'b1, 32'h7777_8888};

    #3;
    check_reset_outputs("por");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    for (int k = 0; k < 6; k++) run_xfer(vecs[k], $sformatf("v%0d", k));

    // Both requesters held from reset release: expect 0,1,0,1 and never two dones
    HRESETn = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    HRDATA = 32'h1111_0000;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.id = k[0]; e.err = 1'b0; e.rdata = 32'h1111_0000;
      sb_q.push_back(e);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      @(negedge HCLK);
      if (done0 || done1) begin
        check("rr_onehot", 64'(done0 & done1), 64'd0);
        pop_and_check($sformatf("rr%0d", ndone));
        ndone++;
        if (ndone == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("rr_count", 64'(ndone), 64'd4);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    check("rr_quiet", 64'({HSEL, done0, done1}), 64'd0);
    sb_q.delete();

    // Reset during the data phase aborts without done; held request then completes
    rv = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, 0, 2'b00, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    HREADYOUT = 1'b0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check("rst_pre_hready", 64'(HREADY), 64'd0);
    #2 HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge HCLK); #1;
    check("rst_hold_nodone", 64'({done0, done1}), 64'd0);
    HRESETn   = 1'b1;
    HREADYOUT = 1'b1;
    run_xfer(rv, "rst_after");
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
